// File: rtl/tinyqv_instr_prefetch.sv
// Instruction prefetch buffer for TinyQV.
// Collects 32-bit fetch words from the memory controller into a circular buffer of
// 16-bit halfwords and presents one complete (16- or 32-bit) instruction at the head.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   jump_req, jump_target  core redirect and its halfword target address
//   mem_instr_addr         next fetch address to the memory controller
//   mem_instr_jump         fetch restart request (redirect or dropped word)
//   mem_instr_fetch_stall  hold the controller when the buffer is nearly full
//   mem_instr_ready/data   incoming fetch word, [15:0] at mem_instr_addr
//   instr_valid/data/pc    head instruction, its address
//   instr_compressed       head instruction is 16-bit
//   instr_accept           core consumes the head instruction
module tinyqv_instr_prefetch #(
  parameter int unsigned DEPTH_HW = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        jump_req,
  input  logic [23:1] jump_target,
  output logic [23:1] mem_instr_addr,
  output logic        mem_instr_jump,
  output logic        mem_instr_fetch_stall,
  input  logic        mem_instr_ready,
  input  logic [31:0] mem_instr_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [23:1] instr_pc,
  output logic        instr_compressed,
  input  logic        instr_accept
);

  localparam int unsigned PtrW = $clog2(DEPTH_HW);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth      = CntW'(DEPTH_HW);
  localparam logic [CntW-1:0] StallLevel = CntW'(DEPTH_HW - 2);

  logic [15:0]     hw_q [DEPTH_HW];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [CntW-1:0] count_q, count_d, free_slots;
  logic [23:1]     fetch_addr_q, fetch_addr_d;
  logic [23:1]     pc_q, pc_d;
  logic            refetch_q, refetch_d;
  logic            discard_q, discard_d;

  logic [15:0] head, head_next;
  logic        compressed, valid, pop, fetch_ok, push, drop_full;
  logic [1:0]  pop_n;

  always_comb begin
    rd_ptr_inc = rd_ptr_q + PtrW'(1);
    wr_ptr_inc = wr_ptr_q + PtrW'(1);
    head       = hw_q[rd_ptr_q];
    head_next  = hw_q[rd_ptr_inc];
    compressed = (head[1:0] != 2'b11);
    valid      = compressed ? (count_q != '0) : (count_q >= CntW'(2));
    pop        = instr_accept & valid & ~jump_req;
    pop_n      = pop ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    // Slots freed by this cycle's pop are usable by this cycle's push.
    free_slots = Depth - count_q + CntW'(pop_n);
    fetch_ok   = mem_instr_ready & ~jump_req & ~discard_q;
    push       = fetch_ok & (free_slots >= CntW'(2));
    // Word lost for lack of space: ask the controller to restart at fetch_addr.
    drop_full  = fetch_ok & ~push;
  end

  always_comb begin
    count_d      = count_q - CntW'(pop_n) + (push ? CntW'(2) : '0);
    rd_ptr_d     = rd_ptr_q + PtrW'(pop_n);
    wr_ptr_d     = wr_ptr_q + (push ? PtrW'(2) : '0);
    fetch_addr_d = push ? fetch_addr_q + 23'd2 : fetch_addr_q;
    pc_d         = pc_q + 23'(pop_n);
    refetch_d    = drop_full;
    discard_d    = 1'b0;
    if (jump_req) begin
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      fetch_addr_d = jump_target;
      pc_d         = jump_target;
      refetch_d    = 1'b0;
      // The word arriving next cycle still belongs to the old stream.
      discard_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= '0;
      pc_q         <= '0;
      refetch_q    <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      pc_q         <= pc_d;
      refetch_q    <= refetch_d;
      discard_q    <= discard_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (rstn && push) begin
      hw_q[wr_ptr_q]   <= mem_instr_data[15:0];
      hw_q[wr_ptr_inc] <= mem_instr_data[31:16];
    end
  end

  always_comb begin
    mem_instr_addr        = fetch_addr_q;
    mem_instr_jump        = rstn & (jump_req | refetch_q);
    mem_instr_fetch_stall = (count_q > StallLevel);
    instr_valid           = valid;
    instr_compressed      = compressed;
    instr_data            = compressed ? {16'h0000, head} : {head_next, head};
    instr_pc              = pc_q;
  end

endmodule
